// File: rtl/cache_axi_read_arbiter.sv
// Two-requester AXI read-channel arbiter (icache = s0, dcache = s1) feeding one bus master port.
// One burst is outstanding at a time; the address is latched on grant and the read data is steered to the winner.
module cache_axi_read_arbiter #(
    parameter bit FIXED_PRIO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s0_araddr,
    input  logic        s0_arvalid,
    output logic        s0_arready,
    output logic        s0_rvalid,
    input  logic        s0_rready,
    input  logic [31:0] s1_araddr,
    input  logic        s1_arvalid,
    output logic        s1_arready,
    output logic        s1_rvalid,
    input  logic        s1_rready,
    output logic [31:0] s_rdata,
    output logic        s_rlast,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic        m_rlast,
    input  logic        m_rvalid,
    output logic        m_rready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        grant_r;
    logic        grant_s;
    logic        last_grant_r;
    logic        last_grant_s;
    logic [31:0] araddr_r;
    logic [31:0] araddr_s;
    logic        pick_s;
    logic        sel_rready_s;
    logic        in_addr_s;
    logic        in_data_s;

    assign in_addr_s    = (state_r == ST_ADDR);
    assign in_data_s    = (state_r == ST_DATA);
    assign sel_rready_s = grant_r ? s1_rready : s0_rready;

    // Requester selection for a new burst; ties go to dcache or alternate away from the last winner
    always_comb begin
        pick_s = 1'b0;
        if (s0_arvalid && s1_arvalid) begin
            if (FIXED_PRIO) begin
                pick_s = 1'b1;
            end else begin
                pick_s = ~last_grant_r;
            end
        end else if (s1_arvalid) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
    end

    // Next-state, grant latch and burst-completion bookkeeping
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        last_grant_s = last_grant_r;
        araddr_s     = araddr_r;
        case (state_r)
            ST_IDLE: begin
                if (s0_arvalid || s1_arvalid) begin
                    state_s  = ST_ADDR;
                    grant_s  = pick_s;
                    araddr_s = pick_s ? s1_araddr : s0_araddr;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                // the burst is committed once granted, so requester arvalid is not consulted here
                if (m_arready) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (m_rvalid && sel_rready_s && m_rlast) begin
                    state_s      = ST_IDLE;
                    last_grant_s = grant_r;
                end else begin
                    state_s = ST_DATA;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and latched grant/address registers
    always_ff @(posedge clk) begin
        if (rst == 1'b1) begin
            state_r      <= ST_IDLE;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            araddr_r     <= 32'd0;
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            araddr_r     <= araddr_s;
        end
    end

    assign m_araddr   = araddr_r;
    assign m_arvalid  = in_addr_s;
    assign s0_arready = in_addr_s & ~grant_r & m_arready;
    assign s1_arready = in_addr_s &  grant_r & m_arready;
    assign m_rready   = in_data_s & sel_rready_s;
    assign s0_rvalid  = in_data_s & ~grant_r & m_rvalid;
    assign s1_rvalid  = in_data_s &  grant_r & m_rvalid;
    assign s_rdata    = m_rdata;
    assign s_rlast    = m_rlast;

endmodule
